hex_score_display: RTL and testbench
====================================

Name: hex_score_display

Overview:
- Registered, parametrised successor to the board display stage. Drives HEX0-HEX5 and LEDR.
- Converts a binary game score to decimal with a sequential double-dabble engine and shows it on NUM_DIGITS hex digits starting at HEX2.
- Shows the mode digit on HEX0, keeps HEX1 dark, and applies game-state display policy: idle blanking, game-over blink, quit blanking.
- Sits between the game FSM and the board pins.

Parameters:
- NUM_DIGITS, 4: score digits on HEX2 upward; legal range 1..4; unused HEX2-HEX5 positions are blank.
- SCORE_W, 14: width of the binary score input; legal range 4..16.
- BLINK_DIV, 25000000: clock cycles per blink half-period.
- LED_W, 10: LEDR width.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- score  in  SCORE_W  binary score, sampled on score_load.
- score_load  in  1  single-cycle request to convert and display score.
- mode  in  4  mode digit for HEX0; value 4'hF = blank.
- ingame_on  in  1  game running.
- game_over  in  1  game finished.
- user_quit  in  1  user quit; overrides everything.
- ledr_in  in  LED_W  LED pattern from the game.
- busy  out  1  conversion in progress.
- LEDR  out  LED_W  registered LED output.
- HEX0..HEX5  out  7 each  registered active-low segments.

Behaviour:
- Reset (resetn low, asynchronous):
  - all HEX outputs = 7'b1111111; LEDR = 0; busy = 0.
  - BCD display register = 0; pending flag clear; blink phase = visible; FSM in IDLE.
- Decoder (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=blank (1111111).
- Converter FSM states: IDLE, CONV, LATCH.
  - IDLE: when score_load=1, capture score into a shift register, clear BCD work registers, count=0, go to CONV. busy=1 from the next cycle.
  - CONV: one add-3-then-shift step per cycle (each nibble >=5 gets +3, then shift left 1). Go to LATCH after exactly SCORE_W cycles.
  - LATCH: copy work BCD to the display register. If score >= 10^NUM_DIGITS, load all 9s instead (saturation). Then go to IDLE; busy=0 in the cycle after LATCH.
  - Latency: load at edge N; new digits on the HEX pins at edge N+SCORE_W+2.
  - score_load while busy: latch score into a one-deep pending register; the newest value wins. The FSM restarts conversion directly from LATCH with no IDLE cycle. busy stays high throughout.
- Output policy, evaluated every cycle and registered (1-cycle latency from the state inputs). Priority: user_quit > ingame_on > game_over > idle.
  - user_quit=1: all HEX blank, LEDR=0.
  - ingame_on=1: HEX0=mode, score digits shown, LEDR=ledr_in.
  - game_over=1 (ingame_on=0): HEX0=mode; score digits alternate shown/blank every BLINK_DIV cycles; LEDR=0.
  - Otherwise (idle): HEX0=mode, score digits blank, LEDR=0.
  - HEX1 is always blank.
- Blink counter:
  - Runs only in the game-over state. Wraps at BLINK_DIV-1 and toggles the phase on wrap.
  - Forced to 0 / visible whenever the state is not game-over, so entering game-over always starts visible for a full half-period.
- Conversion continues regardless of display state. Reset mid-conversion aborts it and clears the display register to 0.

Optional Feature:
- Macro: HEX_SCORE_LZB_EN.
- Defined: leading zeros of the score are blanked, digit HEX2 always shows (score 0 displays a single "0"), and blanking is computed at LATCH.
- Undefined: all NUM_DIGITS digits are shown, including leading zeros.

Test Plan:
- Reset: assert resetn=0 mid-conversion -> HEX0-5=1111111, LEDR=0, busy=0 immediately; after release with ingame_on=1 and no load, HEX2-5 show 0 (0000 without LZB).
- Conversion: ingame_on=1, NUM_DIGITS=4, SCORE_W=14, load score=1234 at edge N -> busy high N+1..N+15, HEX5..HEX2=1,2,3,4 at edge N+16.
- Saturation and back-to-back loads:
  - load 12000 -> HEX5..HEX2 = 9999.
  - load 5, then load 77 two cycles later -> final display 77 (0077 without LZB); busy never drops between the two conversions.
- Blink: BLINK_DIV=4, game_over=1, ingame_on=0, score 42 -> digits visible 4 cycles, blank 4 cycles, repeating; HEX0 stays steady; LEDR=0.
- Priority: ingame_on=1, ledr_in=10'h3FF, then user_quit=1 -> next edge all HEX blank and LEDR=0. Drop quit with ingame_on=0, game_over=0 -> score blank, HEX0=mode.
- Mode digit: mode=4'hA -> HEX0=0001000; mode=4'hF -> HEX0=1111111; HEX1=1111111 in every state.

Source files
------------

// File: rtl/hex_score_display.sv
// hex_score_display
//   Board display stage: converts a binary game score to decimal with a
//   sequential double-dabble engine and drives the seven-segment digits and
//   LEDs according to the game state.
//
// Ports
//   CLOCK_50    in   system clock
//   resetn      in   asynchronous active-low reset
//   score       in   binary score, sampled when score_load is high
//   score_load  in   single-cycle request to convert and display score
//   mode        in   mode digit for HEX0 (4'hF = blank)
//   ingame_on   in   game running
//   game_over   in   game finished (digits blink)
//   user_quit   in   user quit, blanks everything
//   ledr_in     in   LED pattern from the game
//   busy        out  conversion in progress
//   LEDR        out  registered LED output
//   HEX0..HEX5  out  registered active-low segments
//
// Optional feature macro: HEX_SCORE_LZB_EN
//   Defined   : leading zeros blanked (HEX2 always shown), mask computed at LATCH.
//   Undefined : all NUM_DIGITS digits shown including leading zeros.

module hex_score_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned LED_W      = 10
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_load,
  input  logic [3:0]         mode,
  input  logic               ingame_on,
  input  logic               game_over,
  input  logic               user_quit,
  input  logic [LED_W-1:0]   ledr_in,
  output logic               busy,
  output logic [LED_W-1:0]   LEDR,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
);

  // Five BCD digits cover the largest 16-bit score.
  localparam int unsigned BCD_W     = 20;
  localparam int unsigned DISP_W    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W     = $clog2(SCORE_W);
  localparam int unsigned BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SAT_LIMIT = (NUM_DIGITS == 1) ? 10   :
                                      (NUM_DIGITS == 2) ? 100  :
                                      (NUM_DIGITS == 3) ? 1000 : 10000;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
`ifdef HEX_SCORE_LZB_EN
  // Display register resets to 0, so every digit above HEX2 is leading.
  localparam logic [NUM_DIGITS-1:0] LEAD_RST =
    NUM_DIGITS'((32'd1 << NUM_DIGITS) - 32'd2);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LATCH
  } state_t;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    case (v)
      4'h0:    f_seg = 7'b1000000;
      4'h1:    f_seg = 7'b1111001;
      4'h2:    f_seg = 7'b0100100;
      4'h3:    f_seg = 7'b0110000;
      4'h4:    f_seg = 7'b0011001;
      4'h5:    f_seg = 7'b0010010;
      4'h6:    f_seg = 7'b0000010;
      4'h7:    f_seg = 7'b1111000;
      4'h8:    f_seg = 7'b0000000;
      4'h9:    f_seg = 7'b0010000;
      4'hA:    f_seg = 7'b0001000;
      4'hB:    f_seg = 7'b0000011;
      4'hC:    f_seg = 7'b1000110;
      4'hD:    f_seg = 7'b0100001;
      4'hE:    f_seg = 7'b0000110;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  state_t                r_state;
  logic [SCORE_W-1:0]    r_bin;
  logic [SCORE_W-1:0]    r_score_cap;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_count;
  logic                  r_pend_vld;
  logic [SCORE_W-1:0]    r_pend_val;
  logic                  r_busy;
  logic [DISP_W-1:0]     r_disp;
  logic [NUM_DIGITS-1:0] r_lead;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_blink_hide;
  logic [6:0]            r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
  logic [LED_W-1:0]      r_ledr;

  logic [BCD_W-1:0]      w_bcd_next;
  logic                  w_sat;
  logic [DISP_W-1:0]     w_latch_val;
  logic [NUM_DIGITS-1:0] w_lead;
  logic [15:0]           w_disp_pad;
  logic [3:0]            w_lead_pad;
  logic [6:0]            w_dig_seg [4];
  logic                  w_go_state;
  logic                  w_show;
  logic                  w_restart;
  logic [SCORE_W-1:0]    w_restart_val;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  always_comb begin
    w_bcd_next = r_bcd;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcd_next = {w_bcd_next[BCD_W-2:0], r_bin[SCORE_W-1]};
  end

  assign w_sat       = (32'(r_score_cap) >= SAT_LIMIT);
  assign w_latch_val = w_sat ? {NUM_DIGITS{4'h9}} : r_bcd[DISP_W-1:0];

`ifdef HEX_SCORE_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic run_zero;
    w_lead   = '0;
    run_zero = 1'b1;
    for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
      run_zero = run_zero & (w_latch_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      w_lead[NUM_DIGITS-1-k] = run_zero;
    end
  end
`else
  assign w_lead = '0;
`endif

  // A load arriving in LATCH is newer than anything pending.
  assign w_restart     = score_load | r_pend_vld;
  assign w_restart_val = score_load ? score : r_pend_val;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_score_cap <= '0;
      r_bcd       <= '0;
      r_count     <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_val  <= '0;
      r_busy      <= 1'b0;
      r_disp      <= '0;
`ifdef HEX_SCORE_LZB_EN
      r_lead      <= LEAD_RST;
`else
      r_lead      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (score_load) begin
            r_bin       <= score;
            r_score_cap <= score;
            r_bcd       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_CONV;
          end
        end
        S_CONV: begin
          if (score_load) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= score;
          end
          r_bcd   <= w_bcd_next;
          r_bin   <= {r_bin[SCORE_W-2:0], 1'b0};
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(SCORE_W - 1)) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_disp <= w_latch_val;
          r_lead <= w_lead;
          // Queued work restarts straight from here so busy never drops.
          if (w_restart) begin
            r_bin       <= w_restart_val;
            r_score_cap <= w_restart_val;
            r_bcd       <= '0;
            r_count     <= '0;
            r_pend_vld  <= 1'b0;
            r_state     <= S_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_go_state = ~user_quit & ~ingame_on & game_over;

  // Held at zero/visible outside game-over so each entry starts a full visible half-period.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (w_go_state) begin
      if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt  <= '0;
        r_blink_hide <= ~r_blink_hide;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end else begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end
  end

  assign w_disp_pad = 16'(r_disp);
  assign w_lead_pad = 4'(r_lead);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_dig_seg[i] = SEG_BLANK;
      if (i < NUM_DIGITS && !w_lead_pad[i]) begin
        w_dig_seg[i] = f_seg(w_disp_pad[4*i +: 4]);
      end
    end
  end

  assign w_show = ingame_on | (game_over & ~r_blink_hide);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hex0 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex2 <= SEG_BLANK;
      r_hex3 <= SEG_BLANK;
      r_hex4 <= SEG_BLANK;
      r_hex5 <= SEG_BLANK;
      r_ledr <= '0;
    end else begin
      r_hex1 <= SEG_BLANK;
      if (user_quit) begin
        r_hex0 <= SEG_BLANK;
        r_hex2 <= SEG_BLANK;
        r_hex3 <= SEG_BLANK;
        r_hex4 <= SEG_BLANK;
        r_hex5 <= SEG_BLANK;
        r_ledr <= '0;
      end else begin
        r_hex0 <= f_seg(mode);
        r_hex2 <= w_show ? w_dig_seg[0] : SEG_BLANK;
        r_hex3 <= w_show ? w_dig_seg[1] : SEG_BLANK;
        r_hex4 <= w_show ? w_dig_seg[2] : SEG_BLANK;
        r_hex5 <= w_show ? w_dig_seg[3] : SEG_BLANK;
        r_ledr <= ingame_on ? ledr_in : '0;
      end
    end
  end

  assign busy = r_busy;
  assign LEDR = r_ledr;
  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
  assign HEX2 = r_hex2;
  assign HEX3 = r_hex3;
  assign HEX4 = r_hex4;
  assign HEX5 = r_hex5;

endmodule

// File: tb/tb_hex_score_display.sv
// Testbench for hex_score_display (default build, NUM_DIGITS=4, SCORE_W=14,
// BLINK_DIV=4, LED_W=10).

module tb_hex_score_display;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] SEG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] score;
  logic        score_load;
  logic [3:0]  mode;
  logic        ingame_on, game_over, user_quit;
  logic [9:0]  ledr_in;
  logic        busy;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int errors = 0;
  int checks = 0;

  hex_score_display #(
    .NUM_DIGITS (4),
    .SCORE_W    (14),
    .BLINK_DIV  (4),
    .LED_W      (10)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .score      (score),
    .score_load (score_load),
    .mode       (mode),
    .ingame_on  (ingame_on),
    .game_over  (game_over),
    .user_quit  (user_quit),
    .ledr_in    (ledr_in),
    .busy       (busy),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; score = '0; score_load = 1'b0; mode = 4'd3;
    ingame_on = 1'b0; game_over = 1'b0; user_quit = 1'b0; ledr_in = '0;
    repeat (2) tick();
    checks++;
    if ({busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {1'b0, 10'h000, {6{BL}}}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ledr=%h hex=%b_%b_%b_%b_%b_%b want 0/000/all blank",
               busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
    end
    resetn = 1'b1; ingame_on = 1'b1; ledr_in = 10'h3FF;
    tick();
    checks++;
    if (LEDR !== 10'h3FF) begin
      errors++; $display("FAIL reset_ledr_live: got %h want 3ff", LEDR);
    end
    score = 14'd1000; score_load = 1'b1;
    tick();
    score_load = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy: got %b want 1", busy);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {1'b0, 10'h000, {6{BL}}}) begin
      errors++;
      $display("FAIL reset_async: got busy=%b ledr=%h hex=%b_%b_%b_%b_%b_%b want 0/000/all blank",
               busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
    end
    #1 resetn = 1'b1;
    tick();
    checks++;
    if ({busy, HEX0, HEX1, HEX5, HEX4, HEX3, HEX2} !== {1'b0, SEG[3], BL, SEG[0], SEG[0], SEG[0], SEG[0]}) begin
      errors++;
      $display("FAIL reset_release: got busy=%b hex0=%b hex1=%b digits=%b_%b_%b_%b want 0 %b %b 0000",
               busy, HEX0, HEX1, HEX5, HEX4, HEX3, HEX2, SEG[3], BL);
    end
    repeat (20) tick();
    checks++;
    if ({busy, HEX5, HEX4, HEX3, HEX2} !== {1'b0, SEG[0], SEG[0], SEG[0], SEG[0]}) begin
      errors++;
      $display("FAIL reset_aborted: got busy=%b digits=%b_%b_%b_%b want 0 and 0000",
               busy, HEX5, HEX4, HEX3, HEX2);
    end
  endtask

  task automatic test_conversion;
    ingame_on = 1'b1; mode = 4'd3;
    score = 14'd1234; score_load = 1'b1;
    tick();                       // edge N
    score_load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL conv_busy_N: got %b want 1", busy);
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL conv_busy_N+%0d: got %b want 1", k, busy);
      end
    end
    tick();                       // edge N+15
    checks++;
    if ({busy, HEX5, HEX4, HEX3, HEX2} !== {1'b0, SEG[0], SEG[0], SEG[0], SEG[0]}) begin
      errors++;
      $display("FAIL conv_N+15: got busy=%b digits=%b_%b_%b_%b want 0 and old 0000",
               busy, HEX5, HEX4, HEX3, HEX2);
    end
    tick();                       // edge N+16
    checks++;
    if ({HEX5, HEX4, HEX3, HEX2} !== {SEG[1], SEG[2], SEG[3], SEG[4]}) begin
      errors++;
      $display("FAIL conv_1234: got %b_%b_%b_%b want %b_%b_%b_%b",
               HEX5, HEX4, HEX3, HEX2, SEG[1], SEG[2], SEG[3], SEG[4]);
    end
  endtask

  task automatic test_saturation;
    logic [13:0] vals [4];
    logic [27:0] exps [4];
    vals = '{14'd12000, 14'd10000, 14'd16383, 14'd0};
    exps = '{{SEG[9], SEG[9], SEG[9], SEG[9]}, {SEG[9], SEG[9], SEG[9], SEG[9]},
             {SEG[9], SEG[9], SEG[9], SEG[9]}, {SEG[0], SEG[0], SEG[0], SEG[0]}};
    for (int i = 0; i < 4; i++) begin
      score = vals[i]; score_load = 1'b1;
      tick();
      score_load = 1'b0;
      repeat (16) tick();
      checks++;
      if ({HEX5, HEX4, HEX3, HEX2} !== exps[i]) begin
        errors++;
        $display("FAIL sat_%0d: got %b_%b_%b_%b want %b", vals[i], HEX5, HEX4, HEX3, HEX2, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    score = 14'd5; score_load = 1'b1;
    tick();                       // edge N
    score_load = 1'b0;
    for (int k = 0; k <= 29; k++) begin
      if (k > 0) begin
        if (k == 2) begin
          score = 14'd77; score_load = 1'b1;
        end
        tick();
        score_load = 1'b0;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL b2b_busy_N+%0d: got %b want 1", k, busy);
      end
      if (k == 16) begin
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2} !== {SEG[0], SEG[0], SEG[0], SEG[5]}) begin
          errors++;
          $display("FAIL b2b_first_0005: got %b_%b_%b_%b want 0005", HEX5, HEX4, HEX3, HEX2);
        end
      end
    end
    tick();                       // edge N+30
    checks++;
    if ({busy, HEX5, HEX4, HEX3, HEX2} !== {1'b0, SEG[0], SEG[0], SEG[0], SEG[5]}) begin
      errors++;
      $display("FAIL b2b_N+30: got busy=%b digits=%b_%b_%b_%b want 0 and 0005",
               busy, HEX5, HEX4, HEX3, HEX2);
    end
    tick();                       // edge N+31
    checks++;
    if ({HEX5, HEX4, HEX3, HEX2} !== {SEG[0], SEG[0], SEG[7], SEG[7]}) begin
      errors++;
      $display("FAIL b2b_final_0077: got %b_%b_%b_%b want 0077", HEX5, HEX4, HEX3, HEX2);
    end
  endtask

  task automatic test_blink;
    logic [27:0] vis;
    logic [27:0] exp_d;
    vis = {SEG[0], SEG[0], SEG[4], SEG[2]};
    ingame_on = 1'b0; game_over = 1'b0; ledr_in = 10'h3FF; mode = 4'd3;
    score = 14'd42; score_load = 1'b1;
    tick();
    score_load = 1'b0;
    repeat (16) tick();
    checks++;
    if ({HEX0, HEX1, HEX5, HEX4, HEX3, HEX2, LEDR} !== {SEG[3], {5{BL}}, 10'h000}) begin
      errors++;
      $display("FAIL idle_blank: got hex0=%b digits=%b_%b_%b_%b ledr=%h want mode3, blank, 000",
               HEX0, HEX5, HEX4, HEX3, HEX2, LEDR);
    end
    game_over = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_d = (((k / 4) % 2) == 0) ? vis : {4{BL}};
      checks++;
      if ({HEX0, HEX1, HEX5, HEX4, HEX3, HEX2, LEDR} !== {SEG[3], BL, exp_d, 10'h000}) begin
        errors++;
        $display("FAIL blink_cycle%0d: got hex0=%b hex1=%b digits=%b_%b_%b_%b ledr=%h want %b %b %b 000",
                 k, HEX0, HEX1, HEX5, HEX4, HEX3, HEX2, LEDR, SEG[3], BL, exp_d);
      end
    end
  endtask

  task automatic test_priority;
    game_over = 1'b0; ingame_on = 1'b1; ledr_in = 10'h3FF; mode = 4'd5;
    tick();
    checks++;
    if ({LEDR, HEX0, HEX5, HEX4, HEX3, HEX2} !== {10'h3FF, SEG[5], SEG[0], SEG[0], SEG[4], SEG[2]}) begin
      errors++;
      $display("FAIL prio_ingame: got ledr=%h hex0=%b digits=%b_%b_%b_%b want 3ff mode5 0042",
               LEDR, HEX0, HEX5, HEX4, HEX3, HEX2);
    end
    user_quit = 1'b1; game_over = 1'b1;
    tick();
    checks++;
    if ({LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {10'h000, {6{BL}}}) begin
      errors++;
      $display("FAIL prio_quit: got ledr=%h hex=%b_%b_%b_%b_%b_%b want 000 all blank",
               LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
    end
    user_quit = 1'b0; ingame_on = 1'b0; game_over = 1'b0;
    tick();
    checks++;
    if ({LEDR, HEX0, HEX1, HEX5, HEX4, HEX3, HEX2} !== {10'h000, SEG[5], {5{BL}}}) begin
      errors++;
      $display("FAIL prio_idle: got ledr=%h hex0=%b hex1=%b digits=%b_%b_%b_%b want 000 mode5 blank",
               LEDR, HEX0, HEX1, HEX5, HEX4, HEX3, HEX2);
    end
    // ingame_on outranks game_over: steady digits, LEDs pass through.
    ingame_on = 1'b1; game_over = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({LEDR, HEX5, HEX4, HEX3, HEX2} !== {10'h3FF, SEG[0], SEG[0], SEG[4], SEG[2]}) begin
        errors++;
        $display("FAIL prio_ingame_over%0d: got ledr=%h digits=%b_%b_%b_%b want 3ff 0042",
                 k, LEDR, HEX5, HEX4, HEX3, HEX2);
      end
    end
    game_over = 1'b0;
  endtask

  task automatic test_mode;
    logic [3:0] modes [8];
    logic [6:0] exps  [8];
    modes = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h9};
    exps  = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
              7'b0000110, 7'b1111111, 7'b1000000, 7'b0010000};
    ingame_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = modes[i];
      tick();
      checks++;
      if ({HEX0, HEX1} !== {exps[i], BL}) begin
        errors++;
        $display("FAIL mode_%h: got hex0=%b hex1=%b want %b %b", modes[i], HEX0, HEX1, exps[i], BL);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_conversion();
    test_saturation();
    test_back_to_back();
    test_blink();
    test_priority();
    test_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
